// File: rtl/mtr_duty_ramp.sv
// Dual-channel drive conditioner for the dual-PWM motor path.
// Turns signed 11-bit drive targets into an 8-bit duty magnitude and a direction bit per channel.
// Duty changes are slew-limited. A channel drains to zero and waits a dead-time dwell before it
// reverses direction. Duty only changes on PWM period boundaries.
module mtr_duty_ramp #(
   parameter int unsigned STEP         = 8,
   parameter int unsigned DEAD_PERIODS = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic [10:0] lft_tgt,
   input  logic [10:0] rght_tgt,
   output logic [7:0]  lft_duty,
   output logic [7:0]  rght_duty,
   output logic        lft_rev,
   output logic        rght_rev,
   output logic        period_tick,
   output logic        ramp_busy
);

   typedef enum logic [1:0] {StRun, StDrain, StDwell} st_e;

   localparam logic [7:0] StepW = 8'(STEP);
   localparam logic [3:0] DeadW = 4'(DEAD_PERIODS);

   // |t| >> 2, saturated to 255 (only -1024 exceeds the range)
   function automatic logic [7:0] tgt_mag(input logic [10:0] t);
      logic [11:0] a;
      a = t[10] ? (12'd0 - {t[10], t}) : {1'b0, t};
      if (a[11:2] > 10'd255) return 8'hFF;
      return a[9:2];
   endfunction

   // Move cur toward tgt by at most StepW; 9-bit differences avoid any wrap
   function automatic logic [7:0] step_to(input logic [7:0] cur, input logic [7:0] tgt);
      logic [8:0] diff;
      if (tgt >= cur) begin
         diff = {1'b0, tgt} - {1'b0, cur};
         if (diff > {1'b0, StepW}) return cur + StepW;
         return tgt;
      end
      diff = {1'b0, cur} - {1'b0, tgt};
      if (diff > {1'b0, StepW}) return cur - StepW;
      return tgt;
   endfunction

   function automatic logic [7:0] drain_step(input logic [7:0] cur);
      return (cur > StepW) ? cur - StepW : 8'h00;
   endfunction

   logic [7:0] cnt_q;
   logic       tick_q;
   logic       busy_q, busy_d;

   st_e        st_q    [2];
   st_e        st_d    [2];
   logic [7:0] cur_q   [2];
   logic [7:0] cur_d   [2];
   logic       rev_q   [2];
   logic       rev_d   [2];
   logic [3:0] dwell_q [2];
   logic [3:0] dwell_d [2];
   logic [7:0] smag_q  [2];
   logic [7:0] smag_d  [2];
   logic       sneg_q  [2];
   logic       sneg_d  [2];
   logic       szero_q [2];
   logic       szero_d [2];

   // Live decode of the target inputs, consumed only at update edges
   logic [7:0] dec_mag  [2];
   logic       dec_neg  [2];
   logic       dec_zero [2];
   logic       mism     [2];

   assign dec_mag[0]  = tgt_mag(lft_tgt);
   assign dec_mag[1]  = tgt_mag(rght_tgt);
   assign dec_neg[0]  = lft_tgt[10];
   assign dec_neg[1]  = rght_tgt[10];
   assign dec_zero[0] = (lft_tgt == 11'd0);
   assign dec_zero[1] = (rght_tgt == 11'd0);
   // A zero target never asks for a reversal
   assign mism[0]     = !dec_zero[0] && (dec_neg[0] != rev_q[0]);
   assign mism[1]     = !dec_zero[1] && (dec_neg[1] != rev_q[1]);

   // Free-running period counter in phase with pwm8; tick marks the last cycle of a period
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= 8'h00;
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_q + 8'd1;
         tick_q <= (cnt_q == 8'hFE);
      end
   end

   // Per-channel slew/reversal FSMs, target sampling and busy flag
   always_comb begin
      busy_d = 1'b0;
      for (int i = 0; i < 2; i++) begin
         st_d[i]    = st_q[i];
         cur_d[i]   = cur_q[i];
         rev_d[i]   = rev_q[i];
         dwell_d[i] = dwell_q[i];
         smag_d[i]  = smag_q[i];
         sneg_d[i]  = sneg_q[i];
         szero_d[i] = szero_q[i];

         if (tick_q) begin
            smag_d[i]  = dec_mag[i];
            sneg_d[i]  = dec_neg[i];
            szero_d[i] = dec_zero[i];
         end

         if (!en) begin
            // Immediate shutdown, direction is kept
            st_d[i]    = StRun;
            cur_d[i]   = 8'h00;
            dwell_d[i] = 4'd0;
         end else if (tick_q) begin
            unique case (st_q[i])
               StRun: begin
                  if (!mism[i]) begin
                     cur_d[i] = step_to(cur_q[i], dec_mag[i]);
                  end else if (cur_q[i] != 8'h00) begin
                     cur_d[i] = drain_step(cur_q[i]);
                     if (cur_d[i] == 8'h00) begin
                        st_d[i]    = StDwell;
                        dwell_d[i] = DeadW;
                     end else begin
                        st_d[i] = StDrain;
                     end
                  end else begin
                     st_d[i]    = StDwell;
                     dwell_d[i] = DeadW;
                  end
               end
               StDrain: begin
                  if (!mism[i]) begin
                     st_d[i]  = StRun;
                     cur_d[i] = step_to(cur_q[i], dec_mag[i]);
                  end else begin
                     cur_d[i] = drain_step(cur_q[i]);
                     if (cur_d[i] == 8'h00) begin
                        st_d[i]    = StDwell;
                        dwell_d[i] = DeadW;
                     end
                  end
               end
               StDwell: begin
                  cur_d[i] = 8'h00;
                  if (!mism[i]) begin
                     st_d[i] = StRun;
                  end else if (dwell_q[i] == 4'd0) begin
                     // Flip with duty still 0; ramping starts next update edge
                     rev_d[i] = !rev_q[i];
                     st_d[i]  = StRun;
                  end else begin
                     dwell_d[i] = dwell_q[i] - 4'd1;
                  end
               end
               default: st_d[i] = StRun;
            endcase
         end

         busy_d = busy_d || (st_d[i] != StRun)
                         || (cur_d[i] != (en ? smag_d[i] : 8'h00))
                         || (!szero_d[i] && (sneg_d[i] != rev_d[i]));
      end
   end

   // Channel state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 2; i++) begin
            st_q[i]    <= StRun;
            cur_q[i]   <= 8'h00;
            rev_q[i]   <= 1'b0;
            dwell_q[i] <= 4'd0;
            smag_q[i]  <= 8'h00;
            sneg_q[i]  <= 1'b0;
            szero_q[i] <= 1'b1;
         end
         busy_q <= 1'b0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            st_q[i]    <= st_d[i];
            cur_q[i]   <= cur_d[i];
            rev_q[i]   <= rev_d[i];
            dwell_q[i] <= dwell_d[i];
            smag_q[i]  <= smag_d[i];
            sneg_q[i]  <= sneg_d[i];
            szero_q[i] <= szero_d[i];
         end
         busy_q <= busy_d;
      end
   end

   assign lft_duty    = cur_q[0];
   assign rght_duty   = cur_q[1];
   assign lft_rev     = rev_q[0];
   assign rght_rev    = rev_q[1];
   assign period_tick = tick_q;
   assign ramp_busy   = busy_q;

endmodule

// File: tb/tb_mtr_duty_ramp.sv
// Directed bench for mtr_duty_ramp with STEP = 8, DEAD_PERIODS = 2.
module tb_mtr_duty_ramp;

   logic        clk;
   logic        rst_n;
   logic        en;
   logic [10:0] lft_tgt;
   logic [10:0] rght_tgt;
   logic [7:0]  lft_duty;
   logic [7:0]  rght_duty;
   logic        lft_rev;
   logic        rght_rev;
   logic        period_tick;
   logic        ramp_busy;

   int n_total;
   int n_pass;
   int n_fail;

   mtr_duty_ramp #(
      .STEP         (8),
      .DEAD_PERIODS (2)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .lft_tgt     (lft_tgt),
      .rght_tgt    (rght_tgt),
      .lft_duty    (lft_duty),
      .rght_duty   (rght_duty),
      .lft_rev     (lft_rev),
      .rght_rev    (rght_rev),
      .period_tick (period_tick),
      .ramp_busy   (ramp_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Advance to just after the next update edge (edge ending a period_tick cycle)
   task automatic next_update();
      int n;
      n = 0;
      @(negedge clk);
      while (!period_tick && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("period_tick_seen", {31'd0, period_tick}, 32'd1);
      @(posedge clk);
      #1;
   endtask

   function automatic int min_i(input int a, input int b);
      return (a < b) ? a : b;
   endfunction

   initial begin
      int tick_bad;
      int dchg_bad;
      logic [7:0] prev;
      n_total  = 0;
      n_pass   = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      en       = 1'b1;
      lft_tgt  = 11'd400;
      rght_tgt = 11'd3;

      // Reset state
      #22;
      chk("rst_lft_duty", lft_duty, 0);
      chk("rst_rght_duty", rght_duty, 0);
      chk("rst_revs", {lft_rev, rght_rev}, 0);
      chk("rst_tick", period_tick, 0);
      chk("rst_busy", ramp_busy, 0);

      // Release at a falling edge; cycle k follows the k-th rising edge
      @(negedge clk);
      rst_n    = 1'b1;
      tick_bad = 0;
      dchg_bad = 0;
      prev     = lft_duty;
      for (int k = 1; k <= 520; k++) begin
         @(posedge clk);
         #1;
         if (period_tick !== ((k == 255) || (k == 511))) tick_bad++;
         if ((lft_duty !== prev) && (k != 256) && (k != 512)) dchg_bad++;
         prev = lft_duty;
         if (k == 255) chk("tick_at_255", period_tick, 1);
         if (k == 256) begin
            chk("ramp_edge1", lft_duty, 8);
            chk("busy_edge1", ramp_busy, 1);
         end
         if (k == 512) begin
            chk("ramp_edge2", lft_duty, 16);
            chk("small_tgt_duty", rght_duty, 0);
            chk("small_tgt_rev", rght_rev, 0);
         end
      end
      chk("tick_only_255_511", tick_bad, 0);
      chk("duty_only_at_update", dchg_bad, 0);

      // Ramp up to 100 (edges 3..13)
      for (int e = 3; e <= 13; e++) begin
         next_update();
         chk("ramp_up", lft_duty, min_i(8 * e, 100));
         chk("ramp_up_rev", lft_rev, 0);
         chk("ramp_up_busy", ramp_busy, (e < 13) ? 1 : 0);
      end

      // Abort a reversal mid-drain; right channel starts toward 1023 meanwhile
      lft_tgt  = 11'(-400);
      rght_tgt = 11'd1023;
      for (int j = 1; j <= 6; j++) begin
         next_update();
         chk("abort_drain", lft_duty, 100 - 8 * j);
      end
      lft_tgt = 11'd400;
      next_update();
      chk("abort_resume", lft_duty, 60);
      chk("abort_rev", lft_rev, 0);
      for (int j = 1; j <= 5; j++) begin
         next_update();
         chk("abort_reramp", lft_duty, min_i(60 + 8 * j, 100));
      end
      chk("sat_pos_partial", rght_duty, 96);

      // Full reversal of the left channel
      lft_tgt = 11'(-400);
      for (int j = 1; j <= 29; j++) begin
         next_update();
         if (j <= 13) begin
            chk("rev_drain", lft_duty, (100 > 8 * j) ? 100 - 8 * j : 0);
            chk("rev_drain_dir", lft_rev, 0);
         end else if (j <= 15) begin
            chk("rev_dwell", lft_duty, 0);
            chk("rev_dwell_dir", lft_rev, 0);
         end else if (j == 16) begin
            chk("rev_flip_duty", lft_duty, 0);
            chk("rev_flip_dir", lft_rev, 1);
         end else begin
            chk("rev_ramp", lft_duty, min_i(8 * (j - 16), 100));
            chk("rev_ramp_dir", lft_rev, 1);
         end
      end
      chk("sat_pos_duty", rght_duty, 255);
      chk("sat_pos_rev", rght_rev, 0);
      chk("settled_busy", ramp_busy, 0);

      // -1024 saturates to 255 reverse
      rght_tgt = 11'h400;
      for (int j = 1; j <= 67; j++) begin
         next_update();
         if (j == 32) chk("neg_drained", rght_duty, 0);
         if (j == 34) chk("neg_dwell_dir", rght_rev, 0);
         if (j == 35) begin
            chk("neg_flip_duty", rght_duty, 0);
            chk("neg_flip_dir", rght_rev, 1);
         end
         if (j == 36) chk("neg_first_step", rght_duty, 8);
      end
      chk("sat_neg_duty", rght_duty, 255);
      chk("sat_neg_rev", rght_rev, 1);
      chk("sat_neg_busy", ramp_busy, 0);

      // en drop while both channels ramp
      lft_tgt  = 11'(-800);
      rght_tgt = 11'(-400);
      next_update();
      chk("pre_en_lft", lft_duty, 108);
      chk("pre_en_rght", rght_duty, 247);
      chk("pre_en_busy", ramp_busy, 1);
      repeat (100) @(posedge clk);
      #1;
      en = 1'b0;
      @(posedge clk);
      #1;
      en = 1'b1;
      chk("en_low_duties", {lft_duty, rght_duty}, 0);
      chk("en_low_revs", {lft_rev, rght_rev}, 2'b11);
      repeat (50) @(posedge clk);
      #1;
      chk("en_hold_zero", {lft_duty, rght_duty}, 0);
      next_update();
      chk("en_restart_lft", lft_duty, 8);
      chk("en_restart_rght", rght_duty, 8);
      chk("en_restart_revs", {lft_rev, rght_rev}, 2'b11);

      // Asynchronous reset mid-ramp, checked before any clock edge
      repeat (20) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_duties", {lft_duty, rght_duty}, 0);
      chk("async_rst_revs", {lft_rev, rght_rev}, 0);
      chk("async_rst_busy", ramp_busy, 0);
      chk("async_rst_tick", period_tick, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
